event_timestamper: RTL and testbench

//  Downstream consumer of the 51-bit free-running cycle counter. Detects edges on a

---
 rtl/event_timestamper_if.sv | 12 +
 rtl/event_timestamper.sv | 113 +++++++++++
 tb/tb_event_timestamper.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/event_timestamper_if.sv
// Capture stream from the timestamper to its consumer.
// The timestamper drives the master side and the consumer drives the slave side.
interface event_timestamper_if #(
  parameter int TS_W = 51
) ();
  logic            out_valid;
  logic            out_ready;
  logic [TS_W-1:0] out_ts;

  modport master (output out_valid, output out_ts, input out_ready);
  modport slave  (input out_valid, input out_ts, output out_ready);
endinterface

// File: rtl/event_timestamper.sv
// Edge-triggered timestamp capture into a first-word-fall-through FIFO, drained over a valid/ready stream.
// Optional feature macro: EVT_TS_DROP_COUNT_EN adds a saturating drop_count output.
module event_timestamper #(
  parameter int TS_W      = 51,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int EDGE_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TS_W-1:0]   ts_in,
  input  logic              evt_in,
  event_timestamper_if.master stream,
  output logic [ADDR_W:0]   fifo_level,
  output logic              overflow,
  input  logic              clear_ovf
`ifdef EVT_TS_DROP_COUNT_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  logic [TS_W-1:0] mem [DEPTH];

  logic            evt_q_reg;
  logic [ADDR_W:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0] wr_ptr_reg, wr_ptr_next;
  logic            out_valid_reg;
  logic [TS_W-1:0] out_ts_reg;
  logic            overflow_reg;

  logic rise, fall, evt_edge;
  logic full, pop, push, drop;
  logic head_bypass, not_empty_next;

  assign rise = evt_in & ~evt_q_reg;
  assign fall = ~evt_in & evt_q_reg;

  generate
    if (EDGE_MODE == 0) begin : g_rise
      assign evt_edge = rise;
    end else if (EDGE_MODE == 1) begin : g_fall
      assign evt_edge = fall;
    end else begin : g_both
      assign evt_edge = rise | fall;
    end
  endgenerate

  always_comb begin
    full = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
           (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
    pop  = out_valid_reg & stream.out_ready;
    // A full FIFO still accepts a capture when the head is leaving this cycle.
    push = evt_edge & (~full | pop);
    drop = evt_edge & full & ~pop;
    rd_ptr_next = rd_ptr_reg + {{ADDR_W{1'b0}}, pop};
    wr_ptr_next = wr_ptr_reg + {{ADDR_W{1'b0}}, push};
    not_empty_next = (wr_ptr_next != rd_ptr_next);
    // The new head is the word being written right now, so it cannot come from memory yet.
    head_bypass = push && (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_next[ADDR_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[ADDR_W-1:0]] <= ts_in;
    end
  end

  always_ff @(posedge clk) begin
    evt_q_reg <= evt_in;
    if (reset) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_ts_reg    <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      out_valid_reg <= not_empty_next;
      if (not_empty_next) begin
        out_ts_reg <= head_bypass ? ts_in : mem[rd_ptr_next[ADDR_W-1:0]];
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clear_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

`ifdef EVT_TS_DROP_COUNT_EN
  logic [15:0] drop_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_reg <= '0;
    end else if (clear_ovf) begin
      drop_count_reg <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_count_reg != 16'hFFFF)) begin
      drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  assign drop_count = drop_count_reg;
`endif

  assign stream.out_valid = out_valid_reg;
  assign stream.out_ts    = out_ts_reg;
  assign fifo_level       = wr_ptr_reg - rd_ptr_reg;
  assign overflow         = overflow_reg;

endmodule

// File: tb/tb_event_timestamper.sv
// Directed bench: rising-edge instance for capture/overflow/handshake, both-edge instance for dual-edge capture and mid-drain reset.
module tb_event_timestamper;

  localparam int TS_W   = 51;
  localparam int ADDR_W = 3;

  logic            clk;
  logic            reset, reset_b;
  logic [TS_W-1:0] ts_in, ts_b;
  logic            evt_in, evt_b;
  logic            clear_ovf, clear_b;
  logic [ADDR_W:0] fifo_level, level_b;
  logic            overflow, overflow_b;
`ifdef EVT_TS_DROP_COUNT_EN
  logic [15:0]     drop_count, drop_count_b;
`endif

  int total = 0;
  int bad   = 0;

  event_timestamper_if #(.TS_W(TS_W)) sif ();
  event_timestamper_if #(.TS_W(TS_W)) sif_b ();

  event_timestamper #(.TS_W(TS_W), .DEPTH(8), .ADDR_W(ADDR_W), .EDGE_MODE(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .ts_in      (ts_in),
    .evt_in     (evt_in),
    .stream     (sif),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
`ifdef EVT_TS_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  event_timestamper #(.TS_W(TS_W), .DEPTH(8), .ADDR_W(ADDR_W), .EDGE_MODE(2)) dut_b (
    .clk        (clk),
    .reset      (reset_b),
    .ts_in      (ts_b),
    .evt_in     (evt_b),
    .stream     (sif_b),
    .fifo_level (level_b),
    .overflow   (overflow_b),
    .clear_ovf  (clear_b)
`ifdef EVT_TS_DROP_COUNT_EN
    ,
    .drop_count (drop_count_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; reset_b = 1'b1;
    evt_in = 1'b1; evt_b = 1'b0;
    ts_in = '0; ts_b = '0;
    clear_ovf = 1'b0; clear_b = 1'b0;
    sif.out_ready = 1'b0; sif_b.out_ready = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_valid", 64'(sif.out_valid), 64'd0);
    check("rst_ts", 64'(sif.out_ts), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);

    // Release with evt_in held high: no capture
    reset = 1'b0;
    tick();
    check("rel_valid", 64'(sif.out_valid), 64'd0);
    check("rel_level", 64'(fifo_level), 64'd0);
    evt_in = 1'b0;
    tick();
    check("fall_ignored", 64'(fifo_level), 64'd0);

    // Single capture, one-clock latency, consumed next edge
    sif.out_ready = 1'b1;
    ts_in = 100; evt_in = 1'b1;
    tick();
    check("cap_valid", 64'(sif.out_valid), 64'd1);
    check("cap_ts", 64'(sif.out_ts), 64'd100);
    check("cap_level", 64'(fifo_level), 64'd1);
    ts_in = 101;
    tick();
    check("pop_valid", 64'(sif.out_valid), 64'd0);
    check("pop_level", 64'(fifo_level), 64'd0);

    // Ten edges into an eight-deep FIFO with no consumer
    sif.out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      evt_in = 1'b0; tick();
      evt_in = 1'b1; ts_in = 51'(10 * i); tick();
    end
    check("ovf_level", 64'(fifo_level), 64'd8);
    check("ovf_flag", 64'(overflow), 64'd1);
    tick();
    check("stall_ts", 64'(sif.out_ts), 64'd10);
    check("stall_valid", 64'(sif.out_valid), 64'd1);
    sif.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("drain_ts%0d", k), 64'(sif.out_ts), 64'(10 * k));
      check($sformatf("drain_v%0d", k), 64'(sif.out_valid), 64'd1);
      tick();
    end
    check("drained_valid", 64'(sif.out_valid), 64'd0);
    check("drained_level", 64'(fifo_level), 64'd0);

    // Clear overflow
    sif.out_ready = 1'b0;
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    check("clr_ovf", 64'(overflow), 64'd0);
`ifdef EVT_TS_DROP_COUNT_EN
    check("clr_cnt", 64'(drop_count), 64'd0);
`endif

    // Full FIFO with a same-cycle pop and push
    for (int i = 1; i <= 8; i++) begin
      evt_in = 1'b0; tick();
      evt_in = 1'b1; ts_in = 51'(200 + i); tick();
    end
    check("full_level", 64'(fifo_level), 64'd8);
    evt_in = 1'b0; tick();
    evt_in = 1'b1; ts_in = 300; sif.out_ready = 1'b1;
    tick();
    sif.out_ready = 1'b0;
    check("pp_level", 64'(fifo_level), 64'd8);
    check("pp_ovf", 64'(overflow), 64'd0);
    check("pp_head", 64'(sif.out_ts), 64'd202);
    sif.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("pp_drain%0d", k), 64'(sif.out_ts), (k == 7) ? 64'd300 : 64'(202 + k));
      tick();
    end
    check("pp_empty", 64'(sif.out_valid), 64'd0);

    // Drop coinciding with clear_ovf
    sif.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      evt_in = 1'b0; tick();
      evt_in = 1'b1; ts_in = 51'(400 + i); tick();
    end
    evt_in = 1'b0; tick();
    evt_in = 1'b1; ts_in = 500; clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("drop_clr_ovf", 64'(overflow), 64'd1);
    check("drop_clr_level", 64'(fifo_level), 64'd8);
    check("drop_clr_head", 64'(sif.out_ts), 64'd401);
`ifdef EVT_TS_DROP_COUNT_EN
    check("drop_clr_cnt", 64'(drop_count), 64'd1);
    evt_in = 1'b0; tick();
    evt_in = 1'b1; tick();
    check("drop_cnt2", 64'(drop_count), 64'd2);
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    check("drop_cnt_clr", 64'(drop_count), 64'd0);
`endif

    // Both-edge instance: rise at ts 5, fall at ts 6
    reset_b = 1'b0;
    tick();
    check("b_rel_level", 64'(level_b), 64'd0);
    evt_b = 1'b1; ts_b = 5; tick();
    check("b_level1", 64'(level_b), 64'd1);
    check("b_head1", 64'(sif_b.out_ts), 64'd5);
    evt_b = 1'b0; ts_b = 6; tick();
    check("b_level2", 64'(level_b), 64'd2);
    check("b_head2", 64'(sif_b.out_ts), 64'd5);
    sif_b.out_ready = 1'b1; tick();
    check("b_second_ts", 64'(sif_b.out_ts), 64'd6);
    check("b_second_v", 64'(sif_b.out_valid), 64'd1);
    sif_b.out_ready = 1'b0;
    reset_b = 1'b1; tick();
    check("b_rst_valid", 64'(sif_b.out_valid), 64'd0);
    check("b_rst_level", 64'(level_b), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
